// File: rtl/sha3_pkg.sv
// sha3_pkg: shared constants and types for the SHA3-256 message padder.
//   RATE_BITS/RATE_BYTES : 1088-bit / 136-byte SHA3-256 rate block
//   WORD_BITS            : 64-bit input message word
//   WORDS_PER_BLK        : 17 input words per rate block
//   SHA3_DS / KECCAK_DS  : domain-separation byte placed right after the message
//   PAD_END              : closing pad bit, XORed into the last byte of the block
//   state_e              : padder FSM states
package sha3_pkg;

  localparam int RATE_BITS     = 1088;
  localparam int RATE_BYTES    = 136;
  localparam int WORD_BITS     = 64;
  localparam int WORDS_PER_BLK = 17;

  localparam logic [7:0] SHA3_DS   = 8'h06;
  localparam logic [7:0] KECCAK_DS = 8'h01;
  localparam logic [7:0] PAD_END   = 8'h80;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_PADBLK = 2'd1,
    ST_SEND   = 2'd2,
    ST_WAIT   = 2'd3
  } state_e;

  // Valid-byte count of the final word; anything above 8 means a full word.
  function automatic logic [3:0] clamp_bytes(input logic [3:0] nb);
    logic [3:0] r;
    if (nb > 4'd8) begin
      r = 4'd8;
    end else begin
      r = nb;
    end
    return r;
  endfunction

endpackage

// File: rtl/sha3_pad_insert.sv
// sha3_pad_insert: combinational multi-rate padding of one rate block.
//   blk_i : block holding message bytes 0..p_i-1 (later bytes may hold junk)
//   p_i   : number of message bytes in the block, 0..135
//   ds_i  : domain-separation byte written at byte p_i
//   blk_o : bytes < p_i kept, byte p_i = ds_i, later bytes zero, byte 135 ^= 0x80
// Byte k of a block lives at [RATE_BITS-1-8k -: 8] (byte 0 in the MSBs).
module sha3_pad_insert
  import sha3_pkg::*;
(
  input  logic [RATE_BITS-1:0] blk_i,
  input  logic [7:0]           p_i,
  input  logic [7:0]           ds_i,
  output logic [RATE_BITS-1:0] blk_o
);

  // Mask message bytes, drop the domain byte, then close with the end bit.
  always_comb begin
    blk_o = '0;
    for (int k = 0; k < RATE_BYTES; k++) begin
      if (8'(k) < p_i) begin
        blk_o[RATE_BITS-1-8*k -: 8] = blk_i[RATE_BITS-1-8*k -: 8];
      end else if (8'(k) == p_i) begin
        blk_o[RATE_BITS-1-8*k -: 8] = ds_i;
      end else begin
        blk_o[RATE_BITS-1-8*k -: 8] = 8'h00;
      end
    end
    // XOR rather than overwrite so p=135 merges into ds|0x80.
    blk_o[7:0] = blk_o[7:0] ^ PAD_END;
  end

endmodule

// File: rtl/sha3_msg_padder.sv
// sha3_msg_padder: packs a 64-bit word stream into 1088-bit rate blocks,
// pads the final block and hands each block to the SHA3 core as a
// one-cycle strobe gated by the core's hash_next level.
//   clk, rst_n              : clock, synchronous active-low reset
//   msg_data/valid/last     : message word stream, first byte in [63:56]
//   msg_bytes               : valid bytes in the final word (0..8, >8 = 8)
//   msg_ready               : word accepted on a clock edge with msg_valid
//   hash_next               : core ready for the next block (level)
//   blk_data/valid/more     : block, strobe, further-blocks-follow flag
// Build option: define SHA3_PAD_KECCAK_EN for original Keccak padding
// (domain byte 0x01); otherwise FIPS-202 SHA-3 padding (0x06).
module sha3_msg_padder
  import sha3_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [63:0]          msg_data,
  input  logic                 msg_valid,
  input  logic                 msg_last,
  input  logic [3:0]           msg_bytes,
  output logic                 msg_ready,
  input  logic                 hash_next,
  output logic [RATE_BITS-1:0] blk_data,
  output logic                 blk_valid,
  output logic                 blk_more
);

  state_e               state_q, state_d;
  logic [4:0]           wcnt_q, wcnt_d;
  logic [RATE_BITS-1:0] buf_q, buf_d;
  logic                 more_q, more_d;   // more flag for the block in buf_q
  logic                 pend_q, pend_d;   // padding-only block still owed
  logic                 ready_q, ready_d;
  logic [RATE_BITS-1:0] blk_data_q, blk_data_d;
  logic                 blk_valid_q, blk_valid_d;
  logic                 blk_more_q, blk_more_d;

  logic [RATE_BITS-1:0] buf_word_s;
  logic [RATE_BITS-1:0] pad_src_s;
  logic [RATE_BITS-1:0] pad_out_s;
  logic [7:0]           pad_p_s;
  logic [7:0]           p_s;
  logic [7:0]           ds_s;

`ifdef SHA3_PAD_KECCAK_EN
  assign ds_s = KECCAK_DS;
`else
  assign ds_s = SHA3_DS;
`endif

  // Bytes of the block used once the incoming word is placed at slot wcnt.
  assign p_s = {wcnt_q, 3'b000} + {4'b0000, clamp_bytes(msg_bytes)};

  // Buffer with the incoming word dropped into slot wcnt.
  always_comb begin
    buf_word_s = buf_q;
    for (int i = 0; i < WORDS_PER_BLK; i++) begin
      if (5'(i) == wcnt_q) begin
        buf_word_s[RATE_BITS-1-WORD_BITS*i -: WORD_BITS] = msg_data;
      end else begin
        buf_word_s[RATE_BITS-1-WORD_BITS*i -: WORD_BITS] = buf_q[RATE_BITS-1-WORD_BITS*i -: WORD_BITS];
      end
    end
  end

  sha3_pad_insert u_pad (
    .blk_i (pad_src_s),
    .p_i   (pad_p_s),
    .ds_i  (ds_s),
    .blk_o (pad_out_s)
  );

  // Next-state and output logic of the fill / pad / send / wait FSM.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    buf_d       = buf_q;
    more_d      = more_q;
    pend_d      = pend_q;
    blk_data_d  = blk_data_q;
    blk_valid_d = 1'b0;
    blk_more_d  = blk_more_q;
    pad_src_s   = buf_word_s;
    pad_p_s     = p_s;
    case (state_q)
      ST_FILL: begin
        if (msg_valid && ready_q) begin
          if (msg_last) begin
            if (p_s == 8'd136) begin
              // Message ends exactly on the block edge: padding needs its own block.
              buf_d  = buf_word_s;
              more_d = 1'b1;
              pend_d = 1'b1;
            end else begin
              buf_d  = pad_out_s;
              more_d = 1'b0;
              pend_d = 1'b0;
            end
            state_d = ST_SEND;
          end else if (wcnt_q == 5'd16) begin
            buf_d   = buf_word_s;
            more_d  = 1'b1;
            pend_d  = 1'b0;
            state_d = ST_SEND;
          end else begin
            buf_d  = buf_word_s;
            wcnt_d = wcnt_q + 5'd1;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_PADBLK: begin
        pad_src_s = '0;
        pad_p_s   = 8'd0;
        buf_d     = pad_out_s;
        more_d    = 1'b0;
        pend_d    = 1'b0;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (hash_next) begin
          blk_valid_d = 1'b1;
          blk_data_d  = buf_q;
          blk_more_d  = more_q;
          buf_d       = '0;
          wcnt_d      = 5'd0;
          state_d     = ST_WAIT;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT: begin
        // hash_next is stale here; the core drops it one cycle after the strobe.
        if (pend_q) begin
          state_d = ST_PADBLK;
        end else begin
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
    ready_d = (state_d == ST_FILL);
  end

  // State, buffer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      wcnt_q      <= 5'd0;
      buf_q       <= '0;
      more_q      <= 1'b0;
      pend_q      <= 1'b0;
      ready_q     <= 1'b1;
      blk_data_q  <= '0;
      blk_valid_q <= 1'b0;
      blk_more_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      buf_q       <= buf_d;
      more_q      <= more_d;
      pend_q      <= pend_d;
      ready_q     <= ready_d;
      blk_data_q  <= blk_data_d;
      blk_valid_q <= blk_valid_d;
      blk_more_q  <= blk_more_d;
    end
  end

  assign msg_ready = ready_q;
  assign blk_data  = blk_data_q;
  assign blk_valid = blk_valid_q;
  assign blk_more  = blk_more_q;

endmodule
